// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and scoreboard helpers for the integer register file
package regfile_pkg;
  localparam int REG_W   = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;
  typedef logic [REG_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        sb_cnt_t;
  localparam word_t   ZERO_WORD  = '0;
  localparam addr_t   ZERO_ADDR  = '0;
  localparam sb_cnt_t SB_CNT_MAX = 2'd3;
  // Simultaneous issue and write-back cancel out; otherwise saturate at both ends.
  function automatic sb_cnt_t cnt_next(sb_cnt_t c, logic up, logic dn);
    return (up == dn) ? c : up ? ((c == SB_CNT_MAX) ? c : c + 2'd1) : ((c == '0) ? c : c - 2'd1);
  endfunction
  // In-flight writer remains after this cycle's write-back is bypassed.
  function automatic logic pending(sb_cnt_t c, logic hit);
    return (c != '0) && !(hit && c == 2'd1);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register in-flight writer counters between ID issue and write-back
// Ports: clk/rst (async active-low); we/waddr write-back; issue_valid/issue_rd ID issue;
//        re1/raddr1, re2/raddr2 read lookups; pend1/pend2, sb_full, sb_err (sticky underflow).
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  logic  issue_valid,
  input  addr_t issue_rd,
  input  logic  re1,
  input  addr_t raddr1,
  input  logic  re2,
  input  addr_t raddr2,
  output logic  pend1,
  output logic  pend2,
  output logic  sb_full,
  output logic  sb_err
);
  sb_cnt_t cnt [REG_NUM];
  logic dec, iss;
  assign dec = we && waddr != ZERO_ADDR;
  assign iss = issue_valid && issue_rd != ZERO_ADDR;
  assign sb_full = issue_rd != ZERO_ADDR && cnt[issue_rd] == SB_CNT_MAX;
  assign pend1 = re1 && raddr1 != ZERO_ADDR && pending(cnt[raddr1], dec && waddr == raddr1);
  assign pend2 = re2 && raddr2 != ZERO_ADDR && pending(cnt[raddr2], dec && waddr == raddr2);
  // Entry 0 never sees up/dn because both strobes exclude address 0, so it stays 0.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++)
        cnt[i] <= cnt_next(cnt[i], iss && issue_rd == addr_t'(i), dec && waddr == addr_t'(i));
      sb_err <= sb_err || (dec && cnt[waddr] == '0);
    end
endmodule

// File: rtl/regfile.sv
// regfile: x1-x31 integer register file with write-back bypass, scoreboard and retired-write counter
// Ports: clk/rst (async active-low); we/waddr/wdata write-back; re1/raddr1/rdata1 and
//        re2/raddr2/rdata2 combinational reads; issue_valid/issue_rd ID issue;
//        pend1/pend2/sb_full/sb_err scoreboard status; wb_count retired writes.
module regfile
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  logic  re1,
  input  addr_t raddr1,
  output word_t rdata1,
  input  logic  re2,
  input  addr_t raddr2,
  output word_t rdata2,
  input  logic  issue_valid,
  input  addr_t issue_rd,
  output logic  pend1,
  output logic  pend2,
  output logic  sb_full,
  output logic  sb_err,
  output word_t wb_count
);
  word_t regs [REG_NUM];
  logic wr;
  assign wr = we && waddr != ZERO_ADDR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
      wb_count <= ZERO_WORD;
    end else if (wr) begin
      regs[waddr] <= wdata;
      wb_count <= wb_count + 32'd1;
    end
  assign rdata1 = (!re1 || raddr1 == ZERO_ADDR) ? ZERO_WORD : (wr && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (!re2 || raddr2 == ZERO_ADDR) ? ZERO_WORD : (wr && waddr == raddr2) ? wdata : regs[raddr2];
  regfile_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .re1(re1),
    .raddr1(raddr1),
    .re2(re2),
    .raddr2(raddr2),
    .pend1(pend1),
    .pend2(pend2),
    .sb_full(sb_full),
    .sb_err(sb_err)
  );
endmodule
